// File: rtl/fp_cmp_pkg.sv
// Shared encodings for the FloPoCo float comparator: exception classes, predicate
// opcodes and the operand width helper.
package fp_cmp_pkg;

    typedef enum logic [1:0] {
        FP_ZERO = 2'b00,
        FP_NORM = 2'b01,
        FP_INF  = 2'b10,
        FP_NAN  = 2'b11
    } fp_exn_e;

    typedef enum logic [2:0] {
        CMP_EQ    = 3'b000,
        CMP_NE    = 3'b001,
        CMP_LT    = 3'b010,
        CMP_LE    = 3'b011,
        CMP_GT    = 3'b100,
        CMP_GE    = 3'b101,
        CMP_UNORD = 3'b110,
        CMP_ORD   = 3'b111
    } cmp_op_e;

    localparam int OP_W = 3;

    function automatic int fp_w(input int we, input int wf);
        return we + wf + 3;
    endfunction

endpackage

// File: rtl/fp_cmp_lane.sv
// One comparator lane: S1 registers the magnitude relation and the effective signs,
// S2 turns them into the signed predicate result.
module fp_cmp_lane
    import fp_cmp_pkg::*;
#(
    parameter int WE = 11,
    parameter int WF = 22
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s1_load,
    input  logic                    s2_load,
    input  logic [fp_w(WE,WF)-1:0]  a,
    input  logic [fp_w(WE,WF)-1:0]  b,
    input  logic [OP_W-1:0]         op,
    output logic                    res,
    output logic                    unord
);

    localparam int W  = fp_w(WE, WF);
    localparam int MW = WE + WF;

    fp_exn_e       exn_a;
    fp_exn_e       exn_b;
    logic [MW-1:0] mag_a;
    logic [MW-1:0] mag_b;
    logic          sign_a;
    logic          sign_b;
    logic          eq_mag_d;
    logic          lt_mag_d;
    logic          nan_d;

    logic          eq_mag_q;
    logic          lt_mag_q;
    logic          sign_a_q;
    logic          sign_b_q;
    logic          nan_q;

    logic          eq_s;
    logic          lt_s;
    logic          gt_s;
    logic          res_d;

    assign exn_a = fp_exn_e'(a[W-1 -: 2]);
    assign exn_b = fp_exn_e'(b[W-1 -: 2]);
    assign mag_a = a[MW-1:0];
    assign mag_b = b[MW-1:0];

    // A zero's sign is dropped here so that +0 and -0 look identical downstream.
    assign sign_a = a[W-3] & (exn_a != FP_ZERO);
    assign sign_b = b[W-3] & (exn_b != FP_ZERO);
    assign nan_d  = (exn_a == FP_NAN) || (exn_b == FP_NAN);

    always_comb begin
        eq_mag_d = 1'b0;
        lt_mag_d = 1'b0;
        if (exn_a != exn_b) begin
            lt_mag_d = (exn_a < exn_b);
        end else if (exn_a == FP_NORM) begin
            eq_mag_d = (mag_a == mag_b);
            lt_mag_d = (mag_a < mag_b);
        end else begin
            eq_mag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eq_mag_q <= 1'b0;
            lt_mag_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            nan_q    <= 1'b0;
        end else if (s1_load) begin
            eq_mag_q <= eq_mag_d;
            lt_mag_q <= lt_mag_d;
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
            nan_q    <= nan_d;
        end
    end

    // Both negative: larger magnitude is the smaller value.
    always_comb begin
        eq_s = eq_mag_q && (sign_a_q == sign_b_q);
        if (sign_a_q != sign_b_q) begin
            lt_s = sign_a_q;
        end else if (sign_a_q) begin
            lt_s = !lt_mag_q && !eq_mag_q;
        end else begin
            lt_s = lt_mag_q;
        end
        gt_s = !lt_s && !eq_s;
    end

    always_comb begin
        res_d = 1'b0;
        case (op)
            CMP_EQ:    res_d = !nan_q && eq_s;
            CMP_NE:    res_d = nan_q || !eq_s;
            CMP_LT:    res_d = !nan_q && lt_s;
            CMP_LE:    res_d = !nan_q && (lt_s || eq_s);
            CMP_GT:    res_d = !nan_q && gt_s;
            CMP_GE:    res_d = !nan_q && (gt_s || eq_s);
            CMP_UNORD: res_d = nan_q;
            CMP_ORD:   res_d = !nan_q;
            default:   res_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res   <= 1'b0;
            unord <= 1'b0;
        end else if (s2_load) begin
            res   <= res_d;
            unord <= nan_q;
        end
    end

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage multi-lane float comparator with valid/ready flow control; the tag and
// opcode travel with each transaction while lanes compute independently.
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int WE    = 11,
    parameter int WF    = 22,
    parameter int LANES = 3,
    parameter int TAGW  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OP_W-1:0]               in_op,
    input  logic [LANES*fp_w(WE,WF)-1:0]  in_a,
    input  logic [LANES*fp_w(WE,WF)-1:0]  in_b,
    input  logic [TAGW-1:0]               in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0]              out_res,
    output logic [LANES-1:0]              out_unord,
    output logic [TAGW-1:0]               out_tag
);

    localparam int W = fp_w(WE, WF);

    logic            en;
    logic            s1_valid;
    logic            s1_load;
    logic            s2_load;
    logic [OP_W-1:0] s1_op;
    logic [TAGW-1:0] s1_tag;

    // The whole pipe advances together; a stalled output freezes both stages.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign s1_load  = en && in_valid;
    assign s2_load  = en && s1_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_op   <= '0;
            s1_tag  <= '0;
            out_tag <= '0;
        end else begin
            if (s1_load) begin
                s1_op  <= in_op;
                s1_tag <= in_tag;
            end
            if (s2_load) begin
                out_tag <= s1_tag;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp_cmp_lane #(
            .WE (WE),
            .WF (WF)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .s1_load (s1_load),
            .s2_load (s2_load),
            .a       (in_a[i*W +: W]),
            .b       (in_b[i*W +: W]),
            .op      (s1_op),
            .res     (out_res[i]),
            .unord   (out_unord[i])
        );
    end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Bench for fp_compare_pipe: directed vector table, stall/ordering and reset sequences,
// then randomized traffic scored against an ordering-key reference model.
module tb_fp_compare_pipe;

    localparam int WE    = 11;
    localparam int WF    = 22;
    localparam int LANES = 3;
    localparam int TAGW  = 8;
    localparam int W     = WE + WF + 3;
    localparam int AW    = LANES * W;

    localparam logic [35:0] P2   = 36'h500000000;
    localparam logic [35:0] P1   = 36'h4FFC00000;
    localparam logic [35:0] PZ   = 36'h000000000;
    localparam logic [35:0] NZ   = 36'h200000000;
    localparam logic [35:0] N1   = 36'h6FFC00000;
    localparam logic [35:0] N2   = 36'h700000000;
    localparam logic [35:0] PINF = 36'h800000000;
    localparam logic [35:0] NINF = 36'hA00000000;
    localparam logic [35:0] QNAN = 36'hC00000000;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [AW-1:0]   in_a;
    logic [AW-1:0]   in_b;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [LANES-1:0] out_res;
    logic [LANES-1:0] out_unord;
    logic [TAGW-1:0] out_tag;

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [2:0]    res;
        logic [2:0]    unord;
    } vec_t;

    typedef struct {
        bit         v;
        logic [2:0] res;
        logic [2:0] unord;
        logic [7:0] tag;
    } slot_t;

    vec_t  vecs[$];
    slot_t m_s1;
    slot_t m_s2;
    int    tests;
    int    fails;
    int    popped;

    fp_compare_pipe #(
        .WE    (WE),
        .WF    (WF),
        .LANES (LANES),
        .TAGW  (TAGW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_unord (out_unord),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every float maps onto a signed integer whose ordering matches real-number ordering.
    function automatic longint order_key(input logic [35:0] x);
        longint m;
        case (x[35:34])
            2'b00:   m = 0;
            2'b01:   m = 1 + longint'(x[32:0]);
            default: m = longint'(1) << 34;
        endcase
        return x[33] ? -m : m;
    endfunction

    function automatic logic [1:0] ref_pred(input logic [2:0] op, input logic [35:0] a,
                                            input logic [35:0] b);
        bit     nan;
        bit     r;
        longint ka;
        longint kb;
        nan = (a[35:34] == 2'b11) || (b[35:34] == 2'b11);
        ka  = order_key(a);
        kb  = order_key(b);
        r   = 1'b0;
        if (nan) begin
            r = (op == 3'd1) || (op == 3'd6);
        end else begin
            case (op)
                3'd0: r = (ka == kb);
                3'd1: r = (ka != kb);
                3'd2: r = (ka <  kb);
                3'd3: r = (ka <= kb);
                3'd4: r = (ka >  kb);
                3'd5: r = (ka >= kb);
                3'd6: r = 1'b0;
                default: r = 1'b1;
            endcase
        end
        return {nan, r};
    endfunction

    function automatic slot_t model_entry(input logic [2:0] op, input logic [AW-1:0] a,
                                          input logic [AW-1:0] b, input logic [7:0] tag);
        slot_t      s;
        logic [1:0] p;
        s.v   = 1'b1;
        s.tag = tag;
        s.res = '0;
        s.unord = '0;
        for (int l = 0; l < LANES; l++) begin
            p = ref_pred(op, a[l*W +: W], b[l*W +: W]);
            s.unord[l] = p[1];
            s.res[l]   = p[0];
        end
        return s;
    endfunction

    function automatic logic [35:0] rnd_fp();
        logic [35:0] x;
        x[31:0]  = $urandom;
        x[35:32] = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) x[32:22] = 11'(1020 + $urandom_range(0, 6));
        if ($urandom_range(0, 1) == 1) x[21:0]  = 22'($urandom_range(0, 3));
        return x;
    endfunction

    task automatic rnd_pair(output logic [AW-1:0] a, output logic [AW-1:0] b);
        logic [35:0] x;
        logic [35:0] y;
        int          sel;
        for (int l = 0; l < LANES; l++) begin
            x   = rnd_fp();
            y   = rnd_fp();
            sel = $urandom_range(0, 7);
            if (sel < 2) y = x;
            else if (sel == 2) y = x ^ 36'h200000000;
            a[l*W +: W] = x;
            b[l*W +: W] = y;
        end
    endtask

    function automatic void add_vec(input logic [2:0] op,
                                    input logic [35:0] a0, input logic [35:0] b0,
                                    input logic [35:0] a1, input logic [35:0] b1,
                                    input logic [35:0] a2, input logic [35:0] b2,
                                    input logic [2:0] r, input logic [2:0] u);
        vec_t v;
        v.op    = op;
        v.a     = {a2, a1, a0};
        v.b     = {b2, b1, b0};
        v.res   = r;
        v.unord = u;
        vecs.push_back(v);
    endfunction

    task automatic run_vec(input int i);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_op     = vecs[i].op;
        in_a      = vecs[i].a;
        in_b      = vecs[i].b;
        in_tag    = 8'(i);
        #1;
        check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check($sformatf("vec%0d_valid_early", i), 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
        check($sformatf("vec%0d_res", i), 64'(out_res), 64'(vecs[i].res));
        check($sformatf("vec%0d_unord", i), 64'(out_unord), 64'(vecs[i].unord));
        check($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(i));
    endtask

    task automatic step(input bit iv, input bit ordy, input logic [2:0] op,
                        input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [7:0] tag, output bit acc);
        bit en_m;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        #1;
        en_m = !m_s2.v || ordy;
        check("in_ready", 64'(in_ready), 64'(en_m));
        check("out_valid", 64'(out_valid), 64'(m_s2.v));
        if (m_s2.v) begin
            check("out_tag", 64'(out_tag), 64'(m_s2.tag));
            check("out_res", 64'(out_res), 64'(m_s2.res));
            check("out_unord", 64'(out_unord), 64'(m_s2.unord));
            if (ordy) popped++;
        end
        acc = en_m && iv;
        if (en_m) begin
            m_s2 = m_s1;
            if (iv) m_s1 = model_entry(op, a, b, tag);
            else    m_s1.v = 1'b0;
        end
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        bit            acc;
        int            next_tag;

        tests = 0;
        fails = 0;
        popped = 0;
        m_s1 = '{v: 1'b0, res: 3'b0, unord: 3'b0, tag: 8'h0};
        m_s2 = m_s1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_op = 3'd0;
        in_a = '0;
        in_b = '0;
        in_tag = '0;

        add_vec(3'd5, P2, P1, P2, P1, P2, P1, 3'b111, 3'b000);
        add_vec(3'd2, P2, P1, P2, P1, P2, P1, 3'b000, 3'b000);
        add_vec(3'd0, PZ, NZ, PZ, NZ, PZ, NZ, 3'b111, 3'b000);
        add_vec(3'd5, PZ, NZ, PZ, NZ, PZ, NZ, 3'b111, 3'b000);
        add_vec(3'd2, PZ, NZ, PZ, NZ, PZ, NZ, 3'b000, 3'b000);
        add_vec(3'd2, N1, PZ, N1, PZ, N1, PZ, 3'b111, 3'b000);
        for (int op = 0; op < 8; op++) begin
            add_vec(3'(op), QNAN, PINF, QNAN, PINF, QNAN, PINF,
                    (op == 1 || op == 6) ? 3'b111 : 3'b000, 3'b111);
        end
        add_vec(3'd3, P1, P2, N1, N1, PINF, P2, 3'b011, 3'b000);
        add_vec(3'd4, N1, N2, N2, N1, PZ, N1, 3'b101, 3'b000);
        add_vec(3'd0, PINF, 36'h800012345, 36'h000012345, 36'h2000ABCDE, NINF, PINF,
                3'b011, 3'b000);
        add_vec(3'd1, P1, QNAN, P1, P1, NZ, PZ, 3'b001, 3'b001);
        add_vec(3'd2, P1, PINF, NINF, N2, N2, NINF, 3'b011, 3'b000);
        add_vec(3'd7, P1, P2, QNAN, QNAN, NINF, PZ, 3'b101, 3'b010);

        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_res", 64'(out_res), 64'd0);
        check("rst_out_unord", 64'(out_unord), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(i);

        // Eight back-to-back ops with a three-cycle consumer stall in the middle.
        popped = 0;
        next_tag = 0;
        for (int k = 0; k < 40; k++) begin
            if (next_tag == 8 && !m_s1.v && !m_s2.v) break;
            rnd_pair(ra, rb);
            step(next_tag < 8, !(k >= 4 && k < 7), 3'd5, ra, rb, 8'(next_tag), acc);
            if (acc) next_tag++;
        end
        check("burst_accepted", 64'(next_tag), 64'd8);
        check("burst_delivered", 64'(popped), 64'd8);

        // Asynchronous reset with two ops in flight.
        rnd_pair(ra, rb);
        step(1'b1, 1'b0, 3'd3, ra, rb, 8'hA0, acc);
        rnd_pair(ra, rb);
        step(1'b1, 1'b0, 3'd4, ra, rb, 8'hA1, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_tag", 64'(out_tag), 64'd0);
        check("async_rst_res", 64'(out_res), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        m_s1.v = 1'b0;
        m_s2.v = 1'b0;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 3'd0, '0, '0, 8'h00, acc);
        run_vec(5);

        // Randomized traffic with random backpressure.
        m_s1.v = 1'b0;
        m_s2.v = 1'b0;
        for (int k = 0; k < 500; k++) begin
            rnd_pair(ra, rb);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 3'($urandom_range(0, 7)), ra, rb, 8'($urandom), acc);
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 3'd0, '0, '0, 8'h00, acc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
